// File: rtl/my_dmux8way16_seq_if.sv
// Bus bundle for my_dmux8way16_seq: shared producer side plus eight consumer channels.
// The design drives the slave modport; the producer/consumers drive the master modport.
interface my_dmux8way16_seq_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [2:0]       cur_sel;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]       out_valid;
    logic [7:0]       ack;

    modport master (
        output in, in_valid, sel, ack,
        input  in_ready, cur_sel, out_valid, a, b, c, d, e, f, g, h
    );

    modport slave (
        input  in, in_valid, sel, ack,
        output in_ready, cur_sel, out_valid, a, b, c, d, e, f, g, h
    );
endinterface

// File: rtl/my_dmux8way16_seq.sv
// Registered 8-way demultiplexer with per-channel valid/ack handshakes.
// Define MY_DMUX8WAY16_AUTOSEL_EN to steer words round-robin instead of by sel.
module my_dmux8way16_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    my_dmux8way16_seq_if.slave    bus
);

    logic [WIDTH-1:0] data_r [8];
    logic [7:0]       vld_r;
    logic [7:0]       vld_nxt_s;
    logic [7:0]       tgt_oh_s;
    logic [2:0]       tgt_s;
    logic             ready_s;
    logic             accept_s;

`ifdef MY_DMUX8WAY16_AUTOSEL_EN
    logic [2:0] cnt_r;

    // Round-robin pointer: advances only on accepted words, so stalls preserve order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tgt_s = cnt_r;
`else
    assign tgt_s = bus.sel;
`endif

    // Handshake decode; an ack on the target slot frees it in the same cycle
    always_comb begin
        tgt_oh_s  = 8'd1 << tgt_s;
        ready_s   = 1'b0;
        accept_s  = 1'b0;
        vld_nxt_s = vld_r;
        if (!vld_r[tgt_s] || bus.ack[tgt_s]) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = bus.in_valid & ready_s;
        if (accept_s) begin
            vld_nxt_s = (vld_r & ~bus.ack) | tgt_oh_s;
        end else begin
            vld_nxt_s = vld_r & ~bus.ack;
        end
    end

    // Valid flags per channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= 8'h00;
        end else begin
            vld_r <= vld_nxt_s;
        end
    end

    // Holding registers: only the accepted target loads; consumed data is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (accept_s && (tgt_s == 3'(k))) begin
                    data_r[k] <= bus.in;
                end else begin
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    assign bus.a         = data_r[0];
    assign bus.b         = data_r[1];
    assign bus.c         = data_r[2];
    assign bus.d         = data_r[3];
    assign bus.e         = data_r[4];
    assign bus.f         = data_r[5];
    assign bus.g         = data_r[6];
    assign bus.h         = data_r[7];
    assign bus.out_valid = vld_r;
    assign bus.in_ready  = ready_s;
    assign bus.cur_sel   = tgt_s;

endmodule

// File: tb/tb_my_dmux8way16_seq.sv
// Directed bench for my_dmux8way16_seq: a slot-level reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_my_dmux8way16_seq;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   checks;
    int   errors;

    my_dmux8way16_seq_if #(.WIDTH(16)) bus ();

    my_dmux8way16_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: eight slots, each a word plus a full flag
    logic [15:0] m_data [8];
    logic [7:0]  m_vld;
    logic [2:0]  m_cnt;

    function automatic logic [2:0] m_target();
`ifdef MY_DMUX8WAY16_AUTOSEL_EN
        return m_cnt;
`else
        return bus.sel;
`endif
    endfunction

    function automatic logic [15:0] get_ch(input int k);
        case (k)
            0: return bus.a;
            1: return bus.b;
            2: return bus.c;
            3: return bus.d;
            4: return bus.e;
            5: return bus.f;
            6: return bus.g;
            7: return bus.h;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [2:0] t;
        logic       take;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) m_data[k] <= 16'h0000;
            m_vld <= 8'h00;
            m_cnt <= 3'd0;
        end else begin
            t    = m_target();
            take = bus.in_valid && (!m_vld[t] || bus.ack[t]);
            if (take) begin
                m_data[t] <= bus.in;
                m_vld     <= (m_vld & ~bus.ack) | (8'h01 << t);
                m_cnt     <= m_cnt + 3'd1;
            end else begin
                m_vld     <= m_vld & ~bus.ack;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] t;
        if (chk_en) begin
            t = m_target();
            for (int k = 0; k < 8; k++) chk($sformatf("model_ch%0d", k), 32'(get_ch(k)), 32'(m_data[k]));
            chk("model_out_valid", 32'(bus.out_valid), 32'(m_vld));
            chk("model_in_ready", 32'(bus.in_ready), 32'(!m_vld[t] || bus.ack[t]));
            chk("model_cur_sel", 32'(bus.cur_sel), 32'(t));
        end
    end

    task automatic step(input logic [15:0] din, input logic [2:0] s, input logic v, input logic [7:0] k);
        bus.in       = din;
        bus.sel      = s;
        bus.in_valid = v;
        bus.ack      = k;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] fill_vals [8];

    initial begin
        checks       = 0;
        errors       = 0;
        chk_en       = 1'b0;
        rst_n        = 1'b0;
        bus.in       = 16'h0000;
        bus.sel      = 3'd0;
        bus.in_valid = 1'b0;
        bus.ack      = 8'h00;
        fill_vals    = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00,
                         16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'h00);
        chk("reset_a", 32'(bus.a), 32'h0000);
        chk("reset_h", 32'(bus.h), 32'h0000);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
        chk("reset_cur_sel", 32'(bus.cur_sel), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

`ifdef MY_DMUX8WAY16_AUTOSEL_EN
        for (int n = 1; n <= 10; n++) begin
            if (n == 4) begin
                step(16'h0000, 3'd7, 1'b0, 8'h00);
                chk("auto_stall_sel1", 32'(bus.cur_sel), 32'h3);
                step(16'h0000, 3'd7, 1'b0, 8'h00);
                chk("auto_stall_sel2", 32'(bus.cur_sel), 32'h3);
            end
            if (n == 9)       step(16'(n), 3'd7, 1'b1, 8'h01);
            else if (n == 10) step(16'(n), 3'd7, 1'b1, 8'h02);
            else              step(16'(n), 3'd7, 1'b1, 8'h00);
        end
        step(16'h0000, 3'd0, 1'b0, 8'h00);
        chk("auto_a", 32'(bus.a), 32'h0009);
        chk("auto_b", 32'(bus.b), 32'h000A);
        chk("auto_c", 32'(bus.c), 32'h0003);
        chk("auto_f", 32'(bus.f), 32'h0006);
        chk("auto_h", 32'(bus.h), 32'h0008);
        chk("auto_cur_sel", 32'(bus.cur_sel), 32'h2);
        chk("auto_out_valid", 32'(bus.out_valid), 32'hFF);
`else
        for (int i = 0; i < 8; i++) step(fill_vals[i], 3'(i), 1'b1, 8'h00);
        step(16'h0000, 3'd0, 1'b0, 8'h00);
        chk("fill_a", 32'(bus.a), 32'h5555);
        chk("fill_d", 32'(bus.d), 32'hFF00);
        chk("fill_h", 32'(bus.h), 32'hF0F0);
        chk("fill_out_valid", 32'(bus.out_valid), 32'hFF);
        for (int s = 0; s < 8; s++) begin
            bus.in       = 16'hDEAD;
            bus.sel      = 3'(s);
            bus.in_valid = 1'b1;
            #1;
            chk($sformatf("full_in_ready_sel%0d", s), 32'(bus.in_ready), 32'h0);
            @(posedge clk);
            #1;
        end

        // Backpressure on channel 2, then release by ack in the same cycle
        for (int r = 0; r < 3; r++) begin
            bus.in = 16'h1234; bus.sel = 3'd2; bus.in_valid = 1'b1; bus.ack = 8'h00;
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
            @(posedge clk);
            #1;
            chk("bp_c_hold", 32'(bus.c), 32'h00FF);
        end
        bus.ack = 8'h04;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("release_c", 32'(bus.c), 32'h1234);
        chk("release_out_valid", 32'(bus.out_valid), 32'hFF);

        step(16'h0000, 3'd0, 1'b0, 8'hA5);
        chk("multiack_out_valid", 32'(bus.out_valid), 32'h5A);
        chk("multiack_a", 32'(bus.a), 32'h5555);
        chk("multiack_c", 32'(bus.c), 32'h1234);
        chk("multiack_h", 32'(bus.h), 32'hF0F0);

        step(16'h0000, 3'd0, 1'b0, 8'h80);
        chk("spurious_out_valid", 32'(bus.out_valid), 32'h5A);
        chk("spurious_h", 32'(bus.h), 32'hF0F0);

        step(16'h1000, 3'd0, 1'b1, 8'h00);
        step(16'h1002, 3'd2, 1'b1, 8'h00);
        step(16'h1005, 3'd5, 1'b1, 8'h00);
        step(16'h1007, 3'd7, 1'b1, 8'h00);
        step(16'h0000, 3'd0, 1'b0, 8'h00);
        chk("refill_out_valid", 32'(bus.out_valid), 32'hFF);
        chk("refill_f", 32'(bus.f), 32'h1005);

        step(16'h7777, 3'd1, 1'b1, 8'h02);
        chk("passthru_b", 32'(bus.b), 32'h7777);
        chk("passthru_out_valid", 32'(bus.out_valid), 32'hFF);
        step(16'h0000, 3'd0, 1'b0, 8'h00);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'h00);
        chk("async_b", 32'(bus.b), 32'h0000);
        chk("async_g", 32'(bus.g), 32'h0000);
        chk("async_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(16'hBEEF, 3'd6, 1'b1, 8'h00);
        chk("post_reset_g", 32'(bus.g), 32'hBEEF);
        chk("post_reset_out_valid", 32'(bus.out_valid), 32'h40);
`endif
        step(16'h0000, 3'd0, 1'b0, 8'h00);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
